mel_log: RTL

Per-frame logarithm stage directly downstream of the mel filterbank accumulator. It captures the 10 packed mel energies on the filterbank's one-cycle frame-valid pulse and converts each to a fixed-point log2 value, one channel per cycle. It then streams the results channel by channel over a valid/ready handshake toward the DCT/cepstral stage. The log2 is a leading-one position plus linearly interpolated mantissa bits.

---
 rtl/mel_log.sv | 99 +++++++++
 1 files changed

// File: rtl/mel_log.sv
// mel_log: captures a frame of mel energies, converts each to fixed-point log2, streams results.
// Log2 = leading-one position (1-based) concatenated with the next FRAC_W bits below it.
module mel_log #(
    parameter int N_CH   = 10,
    parameter int IN_W   = 47,
    parameter int FRAC_W = 4,
    parameter int OUT_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [N_CH*IN_W-1:0] in_data,
    input  logic [4:0]           in_num,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic [3:0]           out_ch,
    output logic [4:0]           out_num,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overflow,
    output logic [7:0]           drop_cnt
);
    typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  fb_q  [N_CH];
    logic [OUT_W-1:0] res_q [N_CH];
    logic [3:0]       cnt_q;
    logic [4:0]       num_q;
    logic             ovf_q;
    logic [7:0]       drop_q;
    logic             last_ch, capture, send;

    function automatic logic [OUT_W-1:0] log2fx(input logic [IN_W-1:0] x);
        logic [5:0]             p;
        logic [FRAC_W-1:0]      f;
        logic [IN_W+FRAC_W-1:0] y;
        p = '0;
        for (int i = 0; i < IN_W; i++)
            if (x[i]) p = 6'(i + 1);
        y = {x, {FRAC_W{1'b0}}};
        // shifting the padded value puts the bits below the leading one at the bottom
        f = FRAC_W'(y >> (p - 6'd1));
        return (x == '0) ? '0 : {p, f};
    endfunction

    always_comb begin
        last_ch = cnt_q == 4'(N_CH - 1);
        capture = state_q == IDLE && in_valid;
        send    = state_q == SEND;
    end

    always_comb begin
        state_d = capture                              ? CONV :
                  (state_q == CONV && last_ch)          ? SEND :
                  (send && out_ready && last_ch)        ? IDLE : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                num_q <= in_num;
                cnt_q <= '0;
            end else if (state_q == CONV || (send && out_ready)) begin
                cnt_q <= last_ch ? '0 : cnt_q + 4'd1;
            end
            if (in_valid && state_q != IDLE) begin
                ovf_q  <= 1'b1;
                drop_q <= drop_q + {7'd0, ~&drop_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            for (int k = 0; k < N_CH; k++) fb_q[k] <= in_data[k*IN_W +: IN_W];
        if (state_q == CONV)
            res_q[cnt_q] <= log2fx(fb_q[cnt_q]);
    end

    always_comb begin
        out_valid = send;
        out_ch    = send ? cnt_q : '0;
        out_data  = send ? res_q[cnt_q] : '0;
        out_last  = send && last_ch;
        out_num   = num_q;
        busy      = state_q != IDLE;
        overflow  = ovf_q;
        drop_cnt  = drop_q;
    end
endmodule
